// File: rtl/time_counter_if.sv
// Bus between the time-select stage and the time-of-day counter:
// load strobe/value and run enable in; busy, tick, hr/min/sec and expired out.
interface time_counter_if;
    logic        load;
    logic [16:0] load_val;
    logic        enable;
    logic        busy;
    logic        tick;
    logic [4:0]  hr;
    logic [5:0]  min;
    logic [5:0]  sec;
    logic        expired;

    modport master (
        output load, load_val, enable,
        input  busy, tick, hr, min, sec, expired
    );

    modport slave (
        input  load, load_val, enable,
        output busy, tick, hr, min, sec, expired
    );
endinterface

// File: rtl/time_counter.sv
// Time-of-day counter: converts a total-seconds load into hr/min/sec by
// repeated subtraction, then advances the time once per CYCLES_PER_SEC cycles.
// Ports: clk, rst (async, active-low), tc (time_counter_if.slave):
//   load/load_val/enable in; busy/tick/hr/min/sec/expired out.
// Option: define TIME_COUNTER_COUNTDOWN_EN to count down and stop at 00:00:00.
module time_counter #(
    parameter logic [31:0] CYCLES_PER_SEC = 32'd50000000
) (
    input logic           clk,
    input logic           rst,
    time_counter_if.slave tc
);
    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] CONV_H = 2'd1;
    localparam logic [1:0] CONV_M = 2'd2;

    localparam logic [16:0] SEC_PER_DAY = 17'd86400;
    localparam logic [16:0] SEC_PER_HR  = 17'd3600;
    localparam logic [16:0] SEC_PER_MIN = 17'd60;
    localparam logic [31:0] PRESC_LAST  = CYCLES_PER_SEC - 32'd1;

    logic [1:0]  state;
    logic [16:0] rem;
    logic [4:0]  work_hr;
    logic [5:0]  work_min;
    logic [31:0] presc;
    logic [4:0]  hr_q;
    logic [5:0]  min_q;
    logic [5:0]  sec_q;
    logic        busy_q;
    logic        tick_q;
    logic        run_en;
    logic [4:0]  hr_nx;
    logic [5:0]  min_nx;
    logic [5:0]  sec_nx;

`ifdef TIME_COUNTER_COUNTDOWN_EN
    logic expired_q;
    logic at_zero;

    assign at_zero = (hr_q == 5'd0) && (min_q == 6'd0) && (sec_q == 6'd0);
    // Once at midnight the prescaler freezes so no further ticks occur.
    assign run_en  = tc.enable && !at_zero;

    always_comb begin
        hr_nx  = hr_q;
        min_nx = min_q;
        sec_nx = sec_q;
        if (sec_q == 6'd0) begin
            sec_nx = 6'd59;
            if (min_q == 6'd0) begin
                min_nx = 6'd59;
                hr_nx  = hr_q - 5'd1;
            end else begin
                min_nx = min_q - 6'd1;
            end
        end else begin
            sec_nx = sec_q - 6'd1;
        end
    end
`else
    assign run_en = tc.enable;

    always_comb begin
        hr_nx  = hr_q;
        min_nx = min_q;
        sec_nx = sec_q;
        if (sec_q == 6'd59) begin
            sec_nx = 6'd0;
            if (min_q == 6'd59) begin
                min_nx = 6'd0;
                hr_nx  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
            end else begin
                min_nx = min_q + 6'd1;
            end
        end else begin
            sec_nx = sec_q + 6'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            rem      <= '0;
            work_hr  <= '0;
            work_min <= '0;
            presc    <= '0;
            hr_q     <= '0;
            min_q    <= '0;
            sec_q    <= '0;
            busy_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state)
                RUN: begin
                    // A load beats a coincident terminal count.
                    if (tc.load) begin
                        // One subtraction folds any value below 2*86400.
                        rem      <= (tc.load_val >= SEC_PER_DAY) ?
                                    tc.load_val - SEC_PER_DAY : tc.load_val;
                        work_hr  <= '0;
                        work_min <= '0;
                        presc    <= '0;
                        state    <= CONV_H;
                        busy_q   <= 1'b1;
                    end else if (run_en) begin
                        if (presc == PRESC_LAST) begin
                            presc  <= '0;
                            tick_q <= 1'b1;
                            hr_q   <= hr_nx;
                            min_q  <= min_nx;
                            sec_q  <= sec_nx;
                        end else begin
                            presc <= presc + 32'd1;
                        end
                    end
                end
                CONV_H: begin
                    if (rem >= SEC_PER_HR) begin
                        rem     <= rem - SEC_PER_HR;
                        work_hr <= work_hr + 5'd1;
                    end else begin
                        state <= CONV_M;
                    end
                end
                CONV_M: begin
                    if (rem >= SEC_PER_MIN) begin
                        rem      <= rem - SEC_PER_MIN;
                        work_min <= work_min + 6'd1;
                    end else begin
                        // Display registers change only here, all at once.
                        hr_q   <= work_hr;
                        min_q  <= work_min;
                        sec_q  <= rem[5:0];
                        state  <= RUN;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef TIME_COUNTER_COUNTDOWN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            expired_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (tc.load) begin
                        expired_q <= 1'b0;
                    end else if (run_en && presc == PRESC_LAST) begin
                        expired_q <= (hr_nx == 5'd0) && (min_nx == 6'd0) &&
                                     (sec_nx == 6'd0);
                    end
                end
                CONV_M: begin
                    if (rem < SEC_PER_MIN) begin
                        expired_q <= (work_hr == 5'd0) &&
                                     (work_min == 6'd0) &&
                                     (rem[5:0] == 6'd0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign tc.expired = expired_q;
`else
    assign tc.expired = 1'b0;
`endif

    assign tc.busy = busy_q;
    assign tc.tick = tick_q;
    assign tc.hr   = hr_q;
    assign tc.min  = min_q;
    assign tc.sec  = sec_q;
endmodule

// File: tb/tb_time_counter.sv
// Testbench for time_counter: random loads and enable patterns checked
// against a seconds-of-day reference model.
module tb_time_counter;
    localparam int CPS = 4;
`ifdef TIME_COUNTER_COUNTDOWN_EN
    localparam bit COUNTDOWN = 1'b1;
`else
    localparam bit COUNTDOWN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    time_counter_if tc_if ();

    time_counter #(
        .CYCLES_PER_SEC(32'd4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tc (tc_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cur;
    int ecnt;
    bit exp_expired;

    logic [16:0] obs;
    assign obs = {tc_if.hr, tc_if.min, tc_if.sec};

    function automatic logic [16:0] hms(input int t);
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        h = 5'(t / 3600);
        m = 6'((t / 60) % 60);
        s = 6'(t % 60);
        return {h, m, s};
    endfunction

    function automatic int step(input int t);
        if (COUNTDOWN) return (t == 0) ? 0 : t - 1;
        return (t + 1) % 86400;
    endfunction

    function automatic bit stopped(input int t);
        return COUNTDOWN && (t == 0);
    endfunction

    task automatic test_reset;
        tc_if.load     = 1'b0;
        tc_if.load_val = '0;
        tc_if.enable   = 1'b0;
        rst            = 1'b0;
        #2;
        checks++;
        if (obs !== 17'd0)
            $display("FAIL reset_time: got %h required %h", obs, 17'd0);
        checks++;
        if (tc_if.busy !== 1'b0 || tc_if.tick !== 1'b0 || tc_if.expired !== 1'b0)
            $display("FAIL reset_flags: got %b%b%b required 000",
                     tc_if.busy, tc_if.tick, tc_if.expired);
        if (obs !== 17'd0) errors++;
        if (tc_if.busy !== 1'b0 || tc_if.tick !== 1'b0 || tc_if.expired !== 1'b0)
            errors++;
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        cur  = 0;
        ecnt = 0;
        exp_expired = 1'b0;
    endtask

    // Load v; optionally pulse a second load (value 0) at busy cycle poke_at.
    task automatic test_load(input int v, input bit en, input int poke_at);
        int d, n, exp_n, held_bad, tick_bad;
        d     = v % 86400;
        exp_n = d / 3600 + (d % 3600) / 60 + 2;
        tc_if.enable   = en;
        tc_if.load     = 1'b1;
        tc_if.load_val = 17'(v);
        @(negedge clk);
        tc_if.load = 1'b0;
        checks++;
        if (tc_if.expired !== 1'b0) begin
            errors++;
            $display("FAIL load_clears_expired: got %b required 0", tc_if.expired);
        end
        n = 0;
        held_bad = 0;
        tick_bad = 0;
        while (tc_if.busy === 1'b1 && n < 200) begin
            if (obs !== hms(cur)) held_bad++;
            if (tc_if.tick !== 1'b0) tick_bad++;
            tc_if.load     = (n == poke_at);
            tc_if.load_val = '0;
            @(negedge clk);
            n++;
        end
        tc_if.load = 1'b0;
        checks++;
        if (n != exp_n) begin
            errors++;
            $display("FAIL busy_cycles(%0d): got %0d required %0d", v, n, exp_n);
        end
        checks++;
        if (held_bad != 0 || tick_bad != 0) begin
            errors++;
            $display("FAIL held_during_busy(%0d): got %0d/%0d bad cycles required 0/0",
                     v, held_bad, tick_bad);
        end
        cur  = d;
        ecnt = 0;
        exp_expired = COUNTDOWN && (d == 0);
        checks++;
        if (obs !== hms(cur)) begin
            errors++;
            $display("FAIL load_result(%0d): got %0d:%0d:%0d required %0d:%0d:%0d",
                     v, tc_if.hr, tc_if.min, tc_if.sec,
                     cur / 3600, (cur / 60) % 60, cur % 60);
        end
        checks++;
        if (tc_if.expired !== exp_expired) begin
            errors++;
            $display("FAIL load_expired(%0d): got %b required %b",
                     v, tc_if.expired, exp_expired);
        end
    endtask

    task automatic test_run(input int cycles, input int en_pct);
        bit en, exp_tick;
        repeat (cycles) begin
            en = ($urandom_range(0, 99) < en_pct);
            tc_if.enable = en;
            @(negedge clk);
            exp_tick = 1'b0;
            if (en && !stopped(cur)) begin
                ecnt++;
                if (ecnt == CPS) begin
                    ecnt     = 0;
                    exp_tick = 1'b1;
                    cur      = step(cur);
                    if (COUNTDOWN && cur == 0) exp_expired = 1'b1;
                end
            end
            checks++;
            if (tc_if.tick !== exp_tick) begin
                errors++;
                $display("FAIL run_tick: got %b required %b", tc_if.tick, exp_tick);
            end
            checks++;
            if (obs !== hms(cur)) begin
                errors++;
                $display("FAIL run_time: got %0d:%0d:%0d required %0d:%0d:%0d",
                         tc_if.hr, tc_if.min, tc_if.sec,
                         cur / 3600, (cur / 60) % 60, cur % 60);
            end
            checks++;
            if (tc_if.expired !== exp_expired) begin
                errors++;
                $display("FAIL run_expired: got %b required %b",
                         tc_if.expired, exp_expired);
            end
        end
    endtask

    task automatic test_tick_after_load;
        int n;
        test_load(86399, 1'b1, -1);
        n = 0;
        while (tc_if.tick !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        cur = step(cur);
        checks++;
        if (n != CPS) begin
            errors++;
            $display("FAIL first_tick_delay: got %0d required %0d", n, CPS);
        end
        checks++;
        if (obs !== hms(cur)) begin
            errors++;
            $display("FAIL first_tick_time: got %h required %h", obs, hms(cur));
        end
        ecnt = 0;
    endtask

    task automatic test_freeze;
        test_load(10, 1'b0, -1);
        test_run(20, 0);
        test_run(CPS, 100);
    endtask

    task automatic test_load_at_terminal;
        test_load(1000, 1'b1, -1);
        repeat (CPS - 1) @(negedge clk);
        test_load(50000, 1'b1, -1);
    endtask

    task automatic test_reset_mid;
        int bad;
        tc_if.enable   = 1'b0;
        tc_if.load     = 1'b1;
        tc_if.load_val = 17'd45296;
        @(negedge clk);
        tc_if.load = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (tc_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_conv_busy: got %b required 1", tc_if.busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 17'd0 || tc_if.busy !== 1'b0 || tc_if.tick !== 1'b0 ||
            tc_if.expired !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got %h/%b required 0/0", obs, tc_if.busy);
        end
        @(negedge clk);
        rst  = 1'b1;
        cur  = 0;
        ecnt = 0;
        exp_expired = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tc_if.busy !== 1'b0 || obs !== 17'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL no_resume: got %0d bad cycles required 0", bad);
        end
    endtask

    task automatic test_countdown;
        test_load(2, 1'b1, -1);
        test_run(2 * CPS, 100);
        checks++;
        if (obs !== 17'd0 || tc_if.expired !== 1'b1) begin
            errors++;
            $display("FAIL countdown_zero: got %h/%b required 0/1", obs, tc_if.expired);
        end
        test_run(12, 100);
        test_load(5, 1'b1, -1);
        test_run(3 * CPS, 100);
    endtask

    task automatic test_random;
        int v, poke;
        for (int i = 0; i < 5; i++) begin
            v    = int'($urandom_range(0, 131071));
            poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1;
            test_load(v, 1'($urandom_range(0, 1)), poke);
            test_run(30, 75);
        end
    endtask

    initial begin
        test_reset;
        test_load(45296, 1'b0, -1);
        test_tick_after_load;
        test_load(131071, 1'b0, 5);
        test_freeze;
        test_load_at_terminal;
        test_random;
        test_reset_mid;
        if (COUNTDOWN) test_countdown;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
